linescanner_frame_controller: RTL

//  Sequences the line-scanner capture unit to acquire a frame of num_lines lines. Drives its enable,

---
 rtl/linescanner_frame_controller_pkg.sv | 26 ++
 rtl/linescanner_frame_controller_if.sv | 20 ++
 rtl/linescanner_frame_controller_pixel_framer.sv | 78 +++++++
 rtl/linescanner_frame_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/linescanner_frame_controller_pkg.sv
`default_nettype none
// ============================================================================
// linescanner_frame_controller_pkg : shared defaults, FSM encodings, error bits
// Revision: 1.0
// ============================================================================
package linescanner_frame_controller_pkg;

    localparam int DEF_DATA_W          = 8;
    localparam int DEF_PIXELS_PER_LINE = 1024;
    localparam int DEF_LINE_W          = 16;
    localparam int DEF_LVAL_TIMEOUT    = 4096;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARM       = 3'd1;
    localparam logic [2:0] ST_WAIT_LVAL = 3'd2;
    localparam logic [2:0] ST_LINE      = 3'd3;
    localparam logic [2:0] ST_LINE_END  = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SHORT    = 1;
    localparam int ERR_LONG     = 2;
    localparam int ERR_OVERFLOW = 3;

endpackage
`default_nettype wire

// File: rtl/linescanner_frame_controller_if.sv
`default_nettype none
// ============================================================================
// linescanner_frame_controller_if : pixel stream (tdata/tvalid/tready/tuser/tlast)
// Revision: 1.0
// ============================================================================
interface linescanner_frame_controller_if
    import linescanner_frame_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/linescanner_frame_controller_pixel_framer.sv
`default_nettype none
// ============================================================================
// linescanner_frame_controller_pixel_framer : one-deep pixel hold with SOF/EOL marking
// Revision: 1.0
// ============================================================================
module linescanner_frame_controller_pixel_framer
    import linescanner_frame_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              pixel_clock,
    input  wire logic              reset,
    input  wire logic              capture,
    input  wire logic              lval,
    input  wire logic [DATA_W-1:0] data,
    input  wire logic              sof_arm,
    input  wire logic              flush,
    input  wire logic              discard,
    input  wire logic              tready,
    output logic      [DATA_W-1:0] tdata,
    output logic                   tvalid,
    output logic                   tuser,
    output logic                   tlast,
    output logic                   overflow
);

    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic              hold_sof;
    logic              sof_pending;

    // No back-pressure: a beat presented while the sink is not ready is simply lost.
    assign overflow = tvalid & ~tready;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            tdata       <= '0;
            tvalid      <= 1'b0;
            tuser       <= 1'b0;
            tlast       <= 1'b0;
            hold_data   <= '0;
            hold_valid  <= 1'b0;
            hold_sof    <= 1'b0;
            sof_pending <= 1'b0;
        end else begin
            tvalid <= 1'b0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
            if (discard) begin
                hold_valid  <= 1'b0;
                sof_pending <= 1'b0;
            end else begin
                if (sof_arm) begin
                    sof_pending <= 1'b1;
                end
                if (capture && lval) begin
                    if (hold_valid) begin
                        tvalid <= 1'b1;
                        tdata  <= hold_data;
                        tuser  <= hold_sof;
                    end
                    hold_data   <= data;
                    hold_valid  <= 1'b1;
                    hold_sof    <= sof_pending;
                    sof_pending <= 1'b0;
                end else if (flush && hold_valid) begin
                    tvalid     <= 1'b1;
                    tdata      <= hold_data;
                    tuser      <= hold_sof;
                    tlast      <= 1'b1;
                    hold_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/linescanner_frame_controller.sv
`default_nettype none
// ============================================================================
// linescanner_frame_controller : sequences line captures into a framed pixel stream
// Revision: 1.0
// ============================================================================
module linescanner_frame_controller
    import linescanner_frame_controller_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int PIXELS_PER_LINE = DEF_PIXELS_PER_LINE,
    parameter int LINE_W          = DEF_LINE_W,
    parameter int LVAL_TIMEOUT    = DEF_LVAL_TIMEOUT
) (
    input  wire logic              pixel_clock,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic              abort,
    input  wire logic              continuous,
    input  wire logic [LINE_W-1:0] num_lines,
    input  wire logic [7:0]        line_gap,
    output logic                   capture_enable,
    input  wire logic              lval,
    input  wire logic [DATA_W-1:0] data,
    linescanner_frame_controller_if.master m_axis,
    output logic                   busy,
    output logic                   frame_done,
    output logic      [LINE_W-1:0] line_count,
    output logic      [3:0]        err_flags
);

    localparam int                PIX_W      = $clog2(PIXELS_PER_LINE) + 1;
    localparam int                TO_W       = $clog2(LVAL_TIMEOUT) + 1;
    localparam logic [PIX_W-1:0]  PIX_MAX    = '1;
    localparam logic [PIX_W-1:0]  PIX_EXPECT = PIX_W'(PIXELS_PER_LINE);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(LVAL_TIMEOUT - 1);

    logic [2:0]        state;
    logic              cont_q;
    logic [LINE_W-1:0] num_lines_q;
    logic [7:0]        line_gap_q;
    logic [7:0]        gap_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              new_frame;

    logic start_ok;
    logic gap_done;
    logic last_line;
    logic sof_arm;
    logic capture;
    logic flush;
    logic overflow;

    assign start_ok  = (state == ST_IDLE) && start && !abort && (num_lines != '0);
    assign gap_done  = (state == ST_GAP) && (gap_cnt == line_gap_q);
    assign last_line = (line_count + LINE_W'(1)) == num_lines_q;
    assign sof_arm   = start_ok || (gap_done && new_frame && !abort);
    assign capture   = (state == ST_WAIT_LVAL) || (state == ST_LINE);
    assign flush     = (state == ST_LINE) && !lval;
    assign busy      = (state != ST_IDLE);

    linescanner_frame_controller_pixel_framer #(
        .DATA_W (DATA_W)
    ) u_framer (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .capture     (capture),
        .lval        (lval),
        .data        (data),
        .sof_arm     (sof_arm),
        .flush       (flush),
        .discard     (abort),
        .tready      (m_axis.tready),
        .tdata       (m_axis.tdata),
        .tvalid      (m_axis.tvalid),
        .tuser       (m_axis.tuser),
        .tlast       (m_axis.tlast),
        .overflow    (overflow)
    );

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cont_q         <= 1'b0;
            num_lines_q    <= '0;
            line_gap_q     <= '0;
            gap_cnt        <= '0;
            pix_cnt        <= '0;
            to_cnt         <= '0;
            new_frame      <= 1'b0;
            capture_enable <= 1'b0;
            frame_done     <= 1'b0;
            line_count     <= '0;
            err_flags      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state          <= ST_IDLE;
                capture_enable <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            cont_q      <= continuous;
                            num_lines_q <= num_lines;
                            line_gap_q  <= line_gap;
                            err_flags   <= '0;
                            line_count  <= '0;
                            new_frame   <= 1'b0;
                            state       <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        capture_enable <= 1'b1;
                        to_cnt         <= '0;
                        pix_cnt        <= '0;
                        state          <= ST_WAIT_LVAL;
                    end
                    ST_WAIT_LVAL: begin
                        // The pixel that arrives with the lval rise is the first of the line.
                        if (lval) begin
                            capture_enable <= 1'b0;
                            pix_cnt        <= PIX_W'(1);
                            state          <= ST_LINE;
                        end else if (to_cnt >= TO_LAST) begin
                            err_flags[ERR_TIMEOUT] <= 1'b1;
                            capture_enable         <= 1'b0;
                            state                  <= ST_IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    ST_LINE: begin
                        if (lval) begin
                            if (pix_cnt != PIX_MAX) begin
                                pix_cnt <= pix_cnt + PIX_W'(1);
                            end
                        end else begin
                            state <= ST_LINE_END;
                        end
                    end
                    ST_LINE_END: begin
                        if (pix_cnt < PIX_EXPECT) begin
                            err_flags[ERR_SHORT] <= 1'b1;
                        end
                        if (pix_cnt > PIX_EXPECT) begin
                            err_flags[ERR_LONG] <= 1'b1;
                        end
                        line_count <= line_count + LINE_W'(1);
                        gap_cnt    <= '0;
                        if (last_line) begin
                            frame_done <= 1'b1;
                            if (cont_q) begin
                                new_frame <= 1'b1;
                                state     <= ST_GAP;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // line_count holds the finished frame's total until the next frame arms.
                        if (gap_done) begin
                            if (new_frame) begin
                                line_count <= '0;
                                new_frame  <= 1'b0;
                            end
                            state <= ST_ARM;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
            if (overflow) begin
                err_flags[ERR_OVERFLOW] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
